// File: rtl/imem_loader_if.sv
// imem_loader_if: load-control, byte-stream and IMEM write-port bundle for the instruction-memory loader
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [7:0]        ld_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              ld_busy;
  logic              ld_done;
  logic              ld_error;
  logic [7:0]        checksum;
  modport master (
    output ld_start, ld_base, ld_count, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, ld_busy, ld_done, ld_error, checksum
  );
  modport slave (
    input  ld_start, ld_base, ld_count, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, ld_busy, ld_done, ld_error, checksum
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into IMEM words, verifies a checksum trailer, holds the CPU in reset meanwhile
module imem_loader #(parameter int ADDR_W = 8) (
  input logic          SYS_clk,
  input logic          SYS_reset,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERROR} state_t;
  localparam int SW = (ADDR_W + 3 > 10) ? ADDR_W + 3 : 10;
  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [7:0]        count;
  logic [7:0]        wcnt;
  logic [1:0]        idx;
  logic [23:0]       word;
  logic [SW-1:0]     end_addr;
  logic              bad_req;
  logic              take;
  // end address is formed wide enough that a request running past the top of IMEM cannot wrap
  assign end_addr = SW'(bus.ld_base) + (SW'(bus.ld_count) << 2);
  assign bad_req  = (bus.ld_count == '0) || (bus.ld_base[1:0] != 2'b00) || (end_addr > (SW'(1) << ADDR_W));
  assign take     = bus.byte_valid && bus.byte_ready;
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state          <= IDLE;
      base           <= '0;
      count          <= '0;
      wcnt           <= '0;
      idx            <= '0;
      word           <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.cpu_hold   <= 1'b0;
      bus.ld_busy    <= 1'b0;
      bus.ld_done    <= 1'b0;
      bus.ld_error   <= 1'b0;
      bus.checksum   <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (bus.ld_start) begin
          base           <= bus.ld_base;
          count          <= bus.ld_count;
          wcnt           <= '0;
          idx            <= '0;
          bus.checksum   <= '0;
          bus.ld_done    <= 1'b0;
          bus.ld_error   <= bad_req;
          bus.ld_busy    <= !bad_req;
          bus.cpu_hold   <= !bad_req;
          bus.byte_ready <= !bad_req;
          state          <= bad_req ? ERROR : RECV;
        end
        RECV: if (take) begin
          word         <= {word[15:0], bus.byte_data};
          bus.checksum <= bus.checksum + bus.byte_data;
          idx          <= idx + 2'd1;
          if (idx == 2'd3) begin
            state          <= WRITE;
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b1;
            bus.mem_addr   <= base + ADDR_W'({wcnt, 2'b00});
            bus.mem_wdata  <= {word, bus.byte_data};
          end
        end
        WRITE: begin
          bus.mem_we     <= 1'b0;
          bus.byte_ready <= 1'b1;
          wcnt           <= wcnt + 8'd1;
          state          <= ({1'b0, wcnt} + 9'd1 < {1'b0, count}) ? RECV : CHECK;
        end
        CHECK: if (take) begin
          bus.byte_ready <= 1'b0;
          bus.ld_busy    <= 1'b0;
          bus.cpu_hold   <= 1'b0;
          bus.ld_done    <= bus.byte_data == bus.checksum;
          bus.ld_error   <= bus.byte_data != bus.checksum;
          state          <= (bus.byte_data == bus.checksum) ? DONE : ERROR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven parameter checks plus randomized image loads against a byte-level reference model
module tb_imem_loader;
  logic SYS_clk = 1'b0;
  logic SYS_reset = 1'b1;
  imem_loader_if #(.ADDR_W(8)) bus();
  imem_loader #(.ADDR_W(8)) dut(.SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .bus(bus));
  always #5 SYS_clk = ~SYS_clk;
  typedef logic [7:0] bq_t[$];
  typedef struct {logic [7:0] base; logic [7:0] cnt; bit err;} pvec_t;
  int total = 0;
  int bad = 0;
  logic [39:0] act_q[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge SYS_clk) if (bus.mem_we) begin
    act_q.push_back({bus.mem_addr, bus.mem_wdata});
    chk("ready_in_write", bus.byte_ready, 0);
  end
  task automatic tick();
    @(posedge SYS_clk);
    #1;
  endtask
  task automatic start_ld(input logic [7:0] b, input logic [7:0] c);
    bus.ld_base = b;
    bus.ld_count = c;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit gaps);
    bit ok;
    ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      bus.byte_valid = 1'b0;
      bus.ld_start = ($urandom_range(0, 3) == 0);
      bus.ld_base = 8'h02;
      bus.ld_count = 8'h00;
      tick();
      bus.ld_start = 1'b0;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.byte_ready;
      tick();
    end
    bus.byte_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask
  task automatic run_load(input logic [7:0] base, input logic [7:0] cnt, input bq_t data, input logic [7:0] trailer, input bit gaps);
    logic [7:0] sum;
    logic [39:0] e;
    int n;
    sum = 8'h00;
    n = cnt;
    act_q.delete();
    start_ld(base, cnt);
    chk("start_busy", {bus.ld_busy, bus.cpu_hold, bus.byte_ready, bus.ld_error}, 4'b1110);
    foreach (data[i]) begin
      send(data[i], gaps);
      sum = sum + data[i];
    end
    send(trailer, gaps);
    chk("end_flags", {bus.ld_done, bus.ld_error}, (trailer == sum) ? 2'b10 : 2'b01);
    chk("end_idle", {bus.cpu_hold, bus.ld_busy, bus.byte_ready}, 3'b000);
    chk("checksum", bus.checksum, sum);
    chk("nwrites", act_q.size(), n);
    for (int i = 0; i < n && i < act_q.size(); i++) begin
      e = {8'(base + 4 * i), data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]};
      chk("write", act_q[i], e);
    end
  endtask
  initial begin
    bq_t img;
    bq_t rnd;
    logic [7:0] s;
    pvec_t pv[7];
    pv = '{'{8'h00, 8'd0, 1'b1}, '{8'h02, 8'd1, 1'b1}, '{8'hF0, 8'd4, 1'b0}, '{8'hF0, 8'd5, 1'b1},
           '{8'hFC, 8'd1, 1'b0}, '{8'h00, 8'd64, 1'b0}, '{8'h00, 8'd65, 1'b1}};
    bus.ld_start = 1'b0;
    bus.ld_base = '0;
    bus.ld_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;
    tick();
    chk("reset_flags", {bus.byte_ready, bus.mem_we, bus.cpu_hold, bus.ld_busy, bus.ld_done, bus.ld_error}, 0);
    chk("reset_data", {bus.mem_addr, bus.mem_wdata, bus.checksum}, 0);
    SYS_reset = 1'b0;
    tick();
    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h03};
    run_load(8'h00, 8'd2, img, 8'h59, 1'b0);
    run_load(8'h00, 8'd2, img, 8'h58, 1'b0);
    foreach (pv[k]) begin
      act_q.delete();
      start_ld(pv[k].base, pv[k].cnt);
      chk("param_flags", {bus.ld_error, bus.ld_busy, bus.cpu_hold}, pv[k].err ? 3'b100 : 3'b011);
      tick();
      tick();
      chk("param_nowrite", act_q.size(), 0);
      SYS_reset = 1'b1;
      #1;
      SYS_reset = 1'b0;
      tick();
    end
    rnd.delete();
    s = 8'h00;
    repeat (16) begin
      rnd.push_back(8'($urandom));
      s = s + rnd[$];
    end
    run_load(8'hF0, 8'd4, rnd, s, 1'b0);
    repeat (6) begin
      int c;
      int b;
      c = $urandom_range(1, 8);
      b = 4 * $urandom_range(0, 64 - c);
      rnd.delete();
      s = 8'h00;
      repeat (4 * c) begin
        rnd.push_back(8'($urandom));
        s = s + rnd[$];
      end
      run_load(8'(b), 8'(c), rnd, ($urandom_range(0, 1) == 1) ? s : s + 8'h01, 1'b1);
    end
    act_q.delete();
    start_ld(8'h10, 8'd2);
    for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), 1'b0);
    SYS_reset = 1'b1;
    #1;
    chk("async_rst_flags", {bus.byte_ready, bus.mem_we, bus.cpu_hold, bus.ld_busy, bus.ld_done, bus.ld_error}, 0);
    chk("async_rst_data", {bus.mem_addr, bus.mem_wdata, bus.checksum}, 0);
    chk("rst_prior_writes", act_q.size(), 1);
    tick();
    SYS_reset = 1'b0;
    tick();
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(8'h10, 8'd2, img, 8'h40, 1'b0);
    img = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load(8'h00, 8'd1, img, 8'hFC, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader for the single-cycle MIPS system. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them to the IMEM write port at consecutive word addresses, then verifies an 8-bit checksum trailer. While loading it holds the CPU in reset so the PC restarts at 0 once the program image is in place.

## Interface
- ADDR_W, 8, byte-address width of IMEM (matches the 8-bit PC value path)
- SYS_clk  in  1  clock; all state updates on rising edge
- SYS_reset  in  1  reset, asynchronous, active-high
- ld_start  in  1  start request, sampled only in IDLE/DONE/ERROR
- ld_base  in  ADDR_W  byte address of first word, sampled with ld_start
- ld_count  in  8  number of 32-bit words to load, sampled with ld_start
- byte_valid  in  1  byte_data valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  IMEM write strobe, one cycle per word
- mem_addr  out  ADDR_W  IMEM byte address (word aligned)
- mem_wdata  out  32  IMEM write data
- cpu_hold  out  1  drive into CPU reset; high while loading
- ld_busy  out  1  high in RECV/WRITE/CHECK
- ld_done  out  1  level; load completed with good checksum
- ld_error  out  1  level; parameter or checksum error
- checksum  out  8  running mod-256 sum of accepted data bytes

## Operation
- States: IDLE, RECV, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + ld_start:
  - Latch base and count. Clear byte index, word counter and checksum. Clear ld_done/ld_error.
  - Error if ld_count==0, ld_base[1:0]!=0, or ld_base + 4*ld_count > 2^ADDR_W. The sum is computed in ADDR_W+3 bits so it cannot wrap.
  - On error go to ERROR; otherwise go to RECV.
- RECV: byte_ready=1. A byte is accepted on a rising edge with byte_valid && byte_ready.
  - First byte goes to [31:24], then [23:16], [15:8], [7:0].
  - checksum += byte, mod 256.
  - The 4th accepted byte moves the FSM to WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_we=1, mem_addr=base+4*word_index, mem_wdata=assembled word.
  - Then word_index++.
  - Next state is RECV if word_index+1 < count, else CHECK.
- CHECK: byte_ready=1. One trailer byte is accepted. It is not added to checksum.
  - Trailer == checksum -> DONE.
  - Otherwise -> ERROR.
- DONE: ld_done=1, cpu_hold=0. ERROR: ld_error=1, cpu_hold=0.
  - Both hold until the next ld_start or reset.
- cpu_hold = 1 in RECV, WRITE and CHECK, and 0 otherwise.
- ld_start while busy is ignored. byte_valid in IDLE/DONE/ERROR is ignored (byte_ready=0).
- IMEM words already written before an error or reset are not rolled back.

## Timing
- Reset values: state=IDLE; byte_ready, mem_we, cpu_hold, ld_busy, ld_done, ld_error = 0; mem_addr=0, mem_wdata=0, checksum=0.
- Reset is asynchronous. Asserting it mid-load returns to IDLE immediately and drops cpu_hold in the same cycle.
- ld_start at edge N -> ld_busy, cpu_hold and byte_ready high after edge N.
  - Error case: ld_error high after edge N.
- 4th byte accepted at edge M -> mem_we high during cycle M..M+1. IMEM captures the write at edge M+1, and byte_ready returns at M+1.
- Throughput with byte_valid held high: 5 cycles per word.
- Full load = 5*count + 1 cycles from the first accept to DONE.
- byte_ready is a registered, state-decoded output. It is not combinationally dependent on byte_valid.
- mem_addr and mem_wdata hold their last values outside WRITE.

## Test plan
- Good load:
  - Stimulus: base=0x00, count=2, bytes 20 08 00 05 | 20 09 00 03, trailer 0x59.
  - Required: writes 0x20080005@0x00 and 0x20090003@0x04; checksum=0x59; ld_done=1; cpu_hold falls.
- Bad checksum:
  - Stimulus: the same image with trailer 0x58.
  - Required: both words written; ld_error=1; ld_done=0.
- Parameter errors:
  - count=0 -> ERROR on the next edge, no mem_we.
  - base=0x02 -> ERROR.
  - base=0xF0, count=4 -> accepted (last write @0xFC).
  - base=0xF0, count=5 -> ERROR.
- Backpressure/gaps:
  - Stimulus: byte_valid toggling 1-0-1 randomly.
  - Required: identical writes; no byte accepted in the WRITE cycle; ld_start during RECV ignored.
- Reset mid-load:
  - Stimulus: assert SYS_reset after word 0 is written and 2 bytes of word 1 are accepted.
  - Required: all outputs return to reset values asynchronously.
  - Then a new ld_start loads cleanly from byte index 0.
- Wrap/checksum overflow:
  - Stimulus: count=1, bytes FF FF FF FF.
  - Required: checksum=0xFC; trailer 0xFC -> DONE.
